pipeline_hazard_unit: RTL and testbench
=======================================

PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk, reset_n.
REQ-002 Parameters SHALL be, one per line:
- WORD_SIZE, 16, address/data width.
- REG_AW, 2, register-address width.
- CNT_W, 16, performance-counter width.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_valid, id_use_rs, id_use_rt  in  1 each  ID holds a real instruction; it reads rs; it reads rt.
- id_rs, id_rt  in  REG_AW  ID source registers.
- id_is_ctrl  in  1  ID holds a branch or jump, resolved in ID.
- id_pred_pc, id_actual_pc  in  WORD_SIZE  predicted next PC; resolved next PC.
- ex_dest, m_dest, wb_dest  in  REG_AW  destination registers of EX, MEM and WB.
- ex_regwrite, m_regwrite, wb_regwrite  in  1  register-write enables of EX, MEM and WB.
- ex_is_load  in  1  EX holds LWD.
- i_ready  in  1  fetch data valid this cycle.
- d_req, d_ready  in  1  MEM holds a memory op; data access complete.
- pc_write, ifid_write, idex_write, exm_write, mwb_write  out  1  latch write enables.
- ifid_bubble, idex_bubble  out  1  load a NOP into the latch.
- pc_redirect  out  1  PC mux selects redirect_pc.
- redirect_pc  out  WORD_SIZE  correct fetch target.
- btb_write  out  1  write BTB with id_actual_pc.
- fwd_a, fwd_b  out  2  forward source: 0 RF, 1 EX, 2 MEM, 3 WB.
- state  out  2  FSM state.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Function
REQ-004 The FSM SHALL have states RUN=0, WAIT_I=1, WAIT_D=2.
- RUN to WAIT_D on d_req & !d_ready.
- RUN to WAIT_I on !i_ready.
- WAIT_D to RUN on d_ready.
- WAIT_I to RUN on i_ready, unless d_req & !d_ready, which goes to WAIT_D.
REQ-005 The D-stall condition SHALL be d_req & !d_ready. While it holds, in any state, all five write enables SHALL be 0, both bubbles 0, and btb_write 0.
REQ-006 load_use SHALL be ex_is_load & ex_regwrate & id_valid & ((id_use_rs & id_rs==ex_dest) | (id_use_rt & id_rt==ex_dest)).
- Response: pc_write=0, ifid_write=0, idex_bubble=1, other enables 1.
- Duration: exactly one cycle per load.
REQ-007 mispredict SHALL be id_valid & id_is_ctrl & (id_pred_pc != id_actual_pc) & !load_use & no D-stall.
- Response: ifid_bubble=1, flush_cnt increment.
REQ-008 btb_write SHALL be id_valid & id_is_ctrl & !load_use & no D-stall.
REQ-009 On mispredict, redirect_pc SHALL register id_actual_pc and a pending flag SHALL set.
- pc_redirect SHALL equal the pending flag.
- The flag SHALL clear on the first cycle with pc_write=1; a new mispredict in that same cycle re-arms it with the new target.
REQ-010 I-stall (!i_ready, no D-stall, no load_use) SHALL give pc_write=0, ifid_bubble=1, other enables 1.
- A pending redirect SHALL be held until i_ready.
REQ-011 With no hazard, all enables SHALL be 1 and both bubbles 0.
REQ-012 Priority SHALL be D-stall > load_use > mispredict/I-stall.
REQ-013 fwd_a SHALL be computed combinationally from id_rs; fwd_b from id_rt.
- Priority: EX (ex_regwrite & !ex_is_load) = 1, then MEM = 2, then WB = 3, else 0.
- The output SHALL be 0 when the corresponding use bit is 0.
REQ-014 stall_cnt SHALL increment once per cycle with pc_write=0. Both counters SHALL saturate at all-ones.

Reset
REQ-015 While reset_n=0:
- state=RUN, pending flag=0, redirect_pc=0, counters=0.
- All write enables 1; bubbles, btb_write, pc_redirect, fwd_a and fwd_b 0.
REQ-016 Reset asserted mid-stall SHALL abandon the stall and any pending redirect immediately.

Configuration
REQ-017 With HAZARD_PERF_CNT_EN defined, stall_cnt and flush_cnt SHALL operate per REQ-014. Without it, both SHALL be constant 0 and no counter registers SHALL exist.

Verification
REQ-018 Load-use: LWD into r1 in EX, ADD r2,r1,r3 in ID.
- Required: one cycle of pc_write=0 and idex_bubble=1.
- Next cycle: fwd_a=2.
REQ-019 D-miss: d_req=1, d_ready=0 for 3 cycles.
- Required: state=2 and all enables 0 for 3 cycles; RUN on the cycle after d_ready=1.
- With the macro: stall_cnt=3.
REQ-020 Mispredict during I-miss: BEQ with id_pred_pc=0x0011, id_actual_pc=0x0020, i_ready=0 for 2 cycles.
- Required: redirect_pc=0x0020 and pc_redirect=1 held.
- Clears on the first cycle with pc_write=1; flush_cnt=1.
REQ-021 Forwarding priority: r2 written by EX (ALU), MEM and WB simultaneously.
- Required: fwd_a=1.
- With ex_is_load=1: load_use stall instead of forwarding.
REQ-022 Reset pulse during WAIT_D with a pending redirect.
- Required: state=0, pc_redirect=0, all enables 1, counters 0.
REQ-023 Counter saturation: with CNT_W=4, 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipeline_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_unit_if
//
// Bundles every pipeline-facing signal of the hazard unit. Clock and reset
// stay plain ports on the unit itself.
//
// Parameters:
//   WORD_SIZE - address/data width (PC values)
//   REG_AW    - register-address width
//   CNT_W     - performance-counter width
//
// Modports:
//   master - the pipeline datapath: drives ID/EX/MEM/WB status, receives the
//            latch enables, bubbles, redirect, BTB write, forwarding selects,
//            FSM state and counters.
//   slave  - the hazard unit: the mirror image of master.
// ---------------------------------------------------------------------------
interface pipeline_hazard_unit_if #(
    parameter int WORD_SIZE = 16,
    parameter int REG_AW    = 2,
    parameter int CNT_W     = 16
);
    // ID stage status
    logic                 id_valid;
    logic                 id_use_rs;
    logic                 id_use_rt;
    logic [REG_AW-1:0]    id_rs;
    logic [REG_AW-1:0]    id_rt;
    logic                 id_is_ctrl;
    logic [WORD_SIZE-1:0] id_pred_pc;
    logic [WORD_SIZE-1:0] id_actual_pc;

    // Downstream destinations and write enables
    logic [REG_AW-1:0]    ex_dest;
    logic [REG_AW-1:0]    m_dest;
    logic [REG_AW-1:0]    wb_dest;
    logic                 ex_regwrite;
    logic                 m_regwrite;
    logic                 wb_regwrite;
    logic                 ex_is_load;

    // Memory handshakes
    logic                 i_ready;
    logic                 d_req;
    logic                 d_ready;

    // Pipeline controls
    logic                 pc_write;
    logic                 ifid_write;
    logic                 idex_write;
    logic                 exm_write;
    logic                 mwb_write;
    logic                 ifid_bubble;
    logic                 idex_bubble;
    logic                 pc_redirect;
    logic [WORD_SIZE-1:0] redirect_pc;
    logic                 btb_write;
    logic [1:0]           fwd_a;
    logic [1:0]           fwd_b;

    // Status
    logic [1:0]           state;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;

    modport master (
        output id_valid, id_use_rs, id_use_rt, id_rs, id_rt, id_is_ctrl,
               id_pred_pc, id_actual_pc,
               ex_dest, m_dest, wb_dest, ex_regwrite, m_regwrite, wb_regwrite,
               ex_is_load, i_ready, d_req, d_ready,
        input  pc_write, ifid_write, idex_write, exm_write, mwb_write,
               ifid_bubble, idex_bubble, pc_redirect, redirect_pc, btb_write,
               fwd_a, fwd_b, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_use_rs, id_use_rt, id_rs, id_rt, id_is_ctrl,
               id_pred_pc, id_actual_pc,
               ex_dest, m_dest, wb_dest, ex_regwrite, m_regwrite, wb_regwrite,
               ex_is_load, i_ready, d_req, d_ready,
        output pc_write, ifid_write, idex_write, exm_write, mwb_write,
               ifid_bubble, idex_bubble, pc_redirect, redirect_pc, btb_write,
               fwd_a, fwd_b, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_unit
//
// Hazard detection, stall/flush control, branch redirect and operand
// forwarding for a 5-stage pipeline with branches resolved in ID.
//
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - pipeline_hazard_unit_if.slave (all pipeline status in,
//              latch enables / bubbles / redirect / BTB write / forwarding
//              selects / FSM state / performance counters out)
//
// Hazard priority: D-stall > load-use > mispredict / I-stall.
//   D-stall    : d_req & !d_ready freezes every latch, no bubbles, no BTB write.
//   load-use   : hold PC and IF/ID, inject a NOP into ID/EX.
//   I-stall    : hold PC, feed a NOP into IF/ID while fetch data is missing.
//   mispredict : flush IF/ID and redirect fetch to the resolved target.
// Latch controls and forwarding selects are combinational so they act in the
// same cycle as the hazard; the FSM state and the redirect are registered.
//
// Build option:
//   HAZARD_PERF_CNT_EN - when defined, stall_cnt counts cycles with
//                        pc_write=0 and flush_cnt counts mispredicts, both
//                        saturating. When undefined, both outputs are tied to
//                        zero and no counter flops are built.
// ---------------------------------------------------------------------------
module pipeline_hazard_unit #(
    parameter int WORD_SIZE = 16,
    parameter int REG_AW    = 2,
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pipeline_hazard_unit_if.slave bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    logic d_stall;
    logic load_use;
    logic ctrl_resolve;
    logic mispredict;

    assign d_stall = bus.d_req & ~bus.d_ready;

    // The loaded value is not available until MEM completes, so a dependent
    // instruction in ID must wait one cycle and then take it from MEM.
    assign load_use = bus.ex_is_load & bus.ex_regwrite & bus.id_valid &
                      ((bus.id_use_rs & (bus.id_rs == bus.ex_dest)) |
                       (bus.id_use_rt & (bus.id_rt == bus.ex_dest)));

    // A branch/jump in ID is only considered resolved when ID actually
    // advances; under a D-stall or load-use it will be re-evaluated later.
    assign ctrl_resolve = bus.id_valid & bus.id_is_ctrl & ~load_use & ~d_stall;
    assign mispredict   = ctrl_resolve & (bus.id_pred_pc != bus.id_actual_pc);

    // -----------------------------------------------------------------------
    // Latch enables and bubbles
    // -----------------------------------------------------------------------
    logic pc_write_int;
    logic ifid_write_int;
    logic idex_write_int;
    logic exm_write_int;
    logic mwb_write_int;
    logic ifid_bubble_int;
    logic idex_bubble_int;
    logic btb_write_int;

    always_comb begin
        pc_write_int    = 1'b1;
        ifid_write_int  = 1'b1;
        idex_write_int  = 1'b1;
        exm_write_int   = 1'b1;
        mwb_write_int   = 1'b1;
        ifid_bubble_int = 1'b0;
        idex_bubble_int = 1'b0;
        btb_write_int   = 1'b0;

        if (!reset_n) begin
            // Reset forces the free-running defaults regardless of inputs.
        end else if (d_stall) begin
            pc_write_int   = 1'b0;
            ifid_write_int = 1'b0;
            idex_write_int = 1'b0;
            exm_write_int  = 1'b0;
            mwb_write_int  = 1'b0;
        end else if (load_use) begin
            pc_write_int    = 1'b0;
            ifid_write_int  = 1'b0;
            idex_bubble_int = 1'b1;
        end else begin
            // I-stall and mispredict share one priority level; both feed a
            // NOP into IF/ID, only the I-stall holds the PC.
            pc_write_int    = bus.i_ready;
            ifid_bubble_int = mispredict | ~bus.i_ready;
            btb_write_int   = ctrl_resolve;
        end
    end

    assign bus.pc_write    = pc_write_int;
    assign bus.ifid_write  = ifid_write_int;
    assign bus.idex_write  = idex_write_int;
    assign bus.exm_write   = exm_write_int;
    assign bus.mwb_write   = mwb_write_int;
    assign bus.ifid_bubble = ifid_bubble_int;
    assign bus.idex_bubble = idex_bubble_int;
    assign bus.btb_write   = btb_write_int;

    // -----------------------------------------------------------------------
    // Control FSM and redirect register
    // -----------------------------------------------------------------------
    state_t               state_reg;
    logic                 pending_reg;
    logic [WORD_SIZE-1:0] redirect_pc_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= RUN;
            pending_reg     <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (d_stall) begin
                        state_reg <= WAIT_D;
                    end else if (!bus.i_ready) begin
                        state_reg <= WAIT_I;
                    end
                end
                WAIT_I: begin
                    if (bus.i_ready) begin
                        state_reg <= d_stall ? WAIT_D : RUN;
                    end
                end
                WAIT_D: begin
                    if (bus.d_ready) begin
                        state_reg <= RUN;
                    end
                end
                default: state_reg <= RUN;
            endcase

            // A mispredict always wins so a new target is never lost, even
            // in the cycle where the PC consumes the previous one.
            if (mispredict) begin
                pending_reg     <= 1'b1;
                redirect_pc_reg <= bus.id_actual_pc;
            end else if (pc_write_int) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign bus.state       = state_reg;
    assign bus.pc_redirect = pending_reg;
    assign bus.redirect_pc = redirect_pc_reg;

    // -----------------------------------------------------------------------
    // Forwarding selects: index 0 -> fwd_a (rs), index 1 -> fwd_b (rt)
    // -----------------------------------------------------------------------
    logic [2*REG_AW-1:0] src_addr_flat;
    logic [1:0]          src_use_flat;
    logic [3:0]          fwd_flat;

    assign src_addr_flat = {bus.id_rt, bus.id_rs};
    assign src_use_flat  = {bus.id_use_rt, bus.id_use_rs};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [REG_AW-1:0] src_addr;
            logic [1:0]        sel;

            assign src_addr = src_addr_flat[gi*REG_AW +: REG_AW];

            // Youngest producer wins. A load in EX has no data yet, so EX is
            // skipped for it; the load-use stall covers that case.
            always_comb begin
                sel = 2'd0;
                if (reset_n && src_use_flat[gi]) begin
                    if (bus.ex_regwrite && !bus.ex_is_load &&
                        (bus.ex_dest == src_addr)) begin
                        sel = 2'd1;
                    end else if (bus.m_regwrite && (bus.m_dest == src_addr)) begin
                        sel = 2'd2;
                    end else if (bus.wb_regwrite && (bus.wb_dest == src_addr)) begin
                        sel = 2'd3;
                    end
                end
            end

            assign fwd_flat[gi*2 +: 2] = sel;
        end
    endgenerate

    assign bus.fwd_a = fwd_flat[1:0];
    assign bus.fwd_b = fwd_flat[3:2];

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (!pc_write_int && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
            end
            if (mispredict && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_reg;
    assign bus.flush_cnt = flush_cnt_reg;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_unit
//
// Directed vectors for pipeline_hazard_unit. Inputs change 1 ns after the
// rising edge, outputs are sampled on the falling edge. Counter expectations
// are tracked cycle by cycle and only compared as non-zero when
// HAZARD_PERF_CNT_EN is defined. CNT_W is 4 so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_unit;

    localparam int WORD_SIZE = 16;
    localparam int REG_AW    = 2;
    localparam int CNT_W     = 4;

    // {pc, ifid, idex, exm, mwb, ifid_bubble, idex_bubble, btb_write}
    localparam logic [7:0] EN_RUN     = 8'b11111_000;
    localparam logic [7:0] EN_DSTALL  = 8'b00000_000;
    localparam logic [7:0] EN_LU      = 8'b00111_010;
    localparam logic [7:0] EN_ISTALL  = 8'b01111_100;
    localparam logic [7:0] EN_IST_MPB = 8'b01111_101;
    localparam logic [7:0] EN_MP_BTB  = 8'b11111_101;
    localparam logic [7:0] EN_BTB     = 8'b11111_001;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_hazard_unit_if #(
        .WORD_SIZE(WORD_SIZE), .REG_AW(REG_AW), .CNT_W(CNT_W)
    ) bus ();

    pipeline_hazard_unit #(
        .WORD_SIZE(WORD_SIZE), .REG_AW(REG_AW), .CNT_W(CNT_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [CNT_W-1:0] exp_stall = '0;
    logic [CNT_W-1:0] exp_flush = '0;
    logic             stall_now = 1'b0;
    logic             flush_now = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %-16s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %-16s got=0x%0h", tag, got);
        end
    endtask

    function automatic logic [7:0] en_vec();
        return {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exm_write,
                bus.mwb_write, bus.ifid_bubble, bus.idex_bubble, bus.btb_write};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : CNT_W'(int'(v) + 1);
    endfunction

    task automatic chk_cnt(input string tag);
`ifdef HAZARD_PERF_CNT_EN
        chk({tag, ".stall"}, 32'(bus.stall_cnt), 32'(exp_stall));
        chk({tag, ".flush"}, 32'(bus.flush_cnt), 32'(exp_flush));
`else
        chk({tag, ".stall"}, 32'(bus.stall_cnt), 32'd0);
        chk({tag, ".flush"}, 32'(bus.flush_cnt), 32'd0);
`endif
    endtask

    task automatic idle();
        bus.id_valid     = 1'b0;
        bus.id_use_rs    = 1'b0;
        bus.id_use_rt    = 1'b0;
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_is_ctrl   = 1'b0;
        bus.id_pred_pc   = '0;
        bus.id_actual_pc = '0;
        bus.ex_dest      = '0;
        bus.m_dest       = '0;
        bus.wb_dest      = '0;
        bus.ex_regwrite  = 1'b0;
        bus.m_regwrite   = 1'b0;
        bus.wb_regwrite  = 1'b0;
        bus.ex_is_load   = 1'b0;
        bus.i_ready      = 1'b1;
        bus.d_req        = 1'b0;
        bus.d_ready      = 1'b0;
    endtask

    // Advance one clock; the counter model follows what the stimulus
    // declared for the cycle that just ended.
    task automatic next_cycle();
        @(posedge clk);
        if (!reset_n) begin
            exp_stall = '0;
            exp_flush = '0;
        end else begin
            if (stall_now) exp_stall = sat_inc(exp_stall);
            if (flush_now) exp_flush = sat_inc(exp_flush);
        end
        stall_now = 1'b0;
        flush_now = 1'b0;
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset with hazards present on the inputs ----------
        idle();
        bus.d_req       = 1'b1;
        bus.id_use_rs   = 1'b1;
        bus.id_rs       = 2'd3;
        bus.wb_dest     = 2'd3;
        bus.wb_regwrite = 1'b1;
        sample();
        sample();
        chk("rst.en",       32'(en_vec()),          32'(EN_RUN));
        chk("rst.state",    32'(bus.state),         32'd0);
        chk("rst.redir",    32'(bus.pc_redirect),   32'd0);
        chk("rst.redir_pc", 32'(bus.redirect_pc),   32'd0);
        chk("rst.fwd_a",    32'(bus.fwd_a),         32'd0);
        chk_cnt("rst");
        #1;
        reset_n = 1'b1;
        idle();
        next_cycle();

        // ---------------- no hazard ----------------------------------------
        sample();
        chk("idle.en",    32'(en_vec()),  32'(EN_RUN));
        chk("idle.state", 32'(bus.state), 32'd0);
        next_cycle();

        // ---------------- load-use: LWD r1 in EX, ADD r2,r1,r3 in ID -------
        bus.ex_is_load  = 1'b1;
        bus.ex_regwrite = 1'b1;
        bus.ex_dest     = 2'd1;
        bus.id_valid    = 1'b1;
        bus.id_use_rs   = 1'b1;
        bus.id_rs       = 2'd1;
        bus.id_use_rt   = 1'b1;
        bus.id_rt       = 2'd3;
        stall_now       = 1'b1;
        sample();
        chk("lu.en", 32'(en_vec()), 32'(EN_LU));
        next_cycle();
        // Bubble now in EX, the load moved to MEM.
        bus.ex_is_load  = 1'b0;
        bus.ex_regwrite = 1'b0;
        bus.ex_dest     = 2'd0;
        bus.m_dest      = 2'd1;
        bus.m_regwrite  = 1'b1;
        sample();
        chk("lu2.en",    32'(en_vec()),  32'(EN_RUN));
        chk("lu2.fwd_a", 32'(bus.fwd_a), 32'd2);
        chk("lu2.fwd_b", 32'(bus.fwd_b), 32'd0);
        next_cycle();

        // ---------------- forwarding priority on r2 -------------------------
        idle();
        bus.id_valid    = 1'b1;
        bus.id_use_rs   = 1'b1;
        bus.id_rs       = 2'd2;
        bus.id_use_rt   = 1'b0;
        bus.id_rt       = 2'd2;
        bus.ex_dest     = 2'd2;
        bus.m_dest      = 2'd2;
        bus.wb_dest     = 2'd2;
        bus.ex_regwrite = 1'b1;
        bus.m_regwrite  = 1'b1;
        bus.wb_regwrite = 1'b1;
        sample();
        chk("fwd.all3",  32'(bus.fwd_a), 32'd1);
        chk("fwd.nouse", 32'(bus.fwd_b), 32'd0);
        chk("fwd.en",    32'(en_vec()),  32'(EN_RUN));
        next_cycle();
        bus.ex_regwrite = 1'b0;
        bus.id_use_rt   = 1'b1;
        bus.id_rt       = 2'd3;
        bus.wb_dest     = 2'd3;
        sample();
        chk("fwd.mem", 32'(bus.fwd_a), 32'd2);
        chk("fwd.wb",  32'(bus.fwd_b), 32'd3);
        next_cycle();
        bus.m_regwrite  = 1'b0;
        bus.wb_dest     = 2'd2;
        bus.id_use_rt   = 1'b0;
        sample();
        chk("fwd.wbonly", 32'(bus.fwd_a), 32'd3);
        next_cycle();
        // Same producer set, but EX is a load: stall, EX is not a source.
        bus.ex_regwrite = 1'b1;
        bus.ex_is_load  = 1'b1;
        bus.m_regwrite  = 1'b1;
        stall_now       = 1'b1;
        sample();
        chk("fwd.ld.en",  32'(en_vec()),  32'(EN_LU));
        chk("fwd.ld.fwd", 32'(bus.fwd_a), 32'd2);
        next_cycle();

        // ---------------- D-miss for 3 cycles ------------------------------
        idle();
        bus.d_req   = 1'b1;
        bus.d_ready = 1'b0;
        stall_now   = 1'b1;
        sample();
        chk("dm1.en",    32'(en_vec()),  32'(EN_DSTALL));
        chk("dm1.state", 32'(bus.state), 32'd0);
        next_cycle();
        // Mispredicting branch in ID is frozen, not resolved.
        bus.id_valid     = 1'b1;
        bus.id_is_ctrl   = 1'b1;
        bus.id_pred_pc   = 16'h0005;
        bus.id_actual_pc = 16'h0006;
        stall_now        = 1'b1;
        sample();
        chk("dm2.en",    32'(en_vec()),  32'(EN_DSTALL));
        chk("dm2.state", 32'(bus.state), 32'd2);
        next_cycle();
        // Load-use pattern also loses to the D-stall.
        bus.id_is_ctrl  = 1'b0;
        bus.ex_is_load  = 1'b1;
        bus.ex_regwrite = 1'b1;
        bus.ex_dest     = 2'd1;
        bus.id_use_rs   = 1'b1;
        bus.id_rs       = 2'd1;
        stall_now       = 1'b1;
        sample();
        chk("dm3.en",    32'(en_vec()),  32'(EN_DSTALL));
        chk("dm3.state", 32'(bus.state), 32'd2);
        chk("dm3.redir", 32'(bus.pc_redirect), 32'd0);
        next_cycle();
        idle();
        bus.d_req   = 1'b1;
        bus.d_ready = 1'b1;
        sample();
        chk("dm4.en",    32'(en_vec()),  32'(EN_RUN));
        chk("dm4.state", 32'(bus.state), 32'd2);
        next_cycle();
        idle();
        sample();
        chk("dm5.state", 32'(bus.state), 32'd0);
        chk("dm5.redir", 32'(bus.pc_redirect), 32'd0);
        chk_cnt("dm5");
        next_cycle();

        // ---------------- mispredict during I-miss --------------------------
        bus.id_valid     = 1'b1;
        bus.id_is_ctrl   = 1'b1;
        bus.id_pred_pc   = 16'h0011;
        bus.id_actual_pc = 16'h0020;
        bus.i_ready      = 1'b0;
        stall_now        = 1'b1;
        flush_now        = 1'b1;
        sample();
        chk("im1.en",    32'(en_vec()),        32'(EN_IST_MPB));
        chk("im1.redir", 32'(bus.pc_redirect), 32'd0);
        next_cycle();
        idle();
        bus.i_ready = 1'b0;
        stall_now   = 1'b1;
        sample();
        chk("im2.en",       32'(en_vec()),        32'(EN_ISTALL));
        chk("im2.state",    32'(bus.state),       32'd1);
        chk("im2.redir",    32'(bus.pc_redirect), 32'd1);
        chk("im2.redir_pc", 32'(bus.redirect_pc), 32'h0020);
        next_cycle();
        idle();
        sample();
        chk("im3.en",       32'(en_vec()),        32'(EN_RUN));
        chk("im3.redir",    32'(bus.pc_redirect), 32'd1);
        chk("im3.redir_pc", 32'(bus.redirect_pc), 32'h0020);
        next_cycle();
        sample();
        chk("im4.redir", 32'(bus.pc_redirect), 32'd0);
        chk("im4.state", 32'(bus.state),       32'd0);
        chk_cnt("im4");
        next_cycle();

        // ---------------- correct prediction, then plain mispredict ---------
        bus.id_valid     = 1'b1;
        bus.id_is_ctrl   = 1'b1;
        bus.id_pred_pc   = 16'h0030;
        bus.id_actual_pc = 16'h0030;
        sample();
        chk("hit.en", 32'(en_vec()), 32'(EN_BTB));
        next_cycle();
        bus.id_pred_pc   = 16'h0040;
        bus.id_actual_pc = 16'h0044;
        flush_now        = 1'b1;
        sample();
        chk("mp.en",    32'(en_vec()),        32'(EN_MP_BTB));
        chk("mp.redir", 32'(bus.pc_redirect), 32'd0);
        next_cycle();
        idle();
        sample();
        chk("mp2.redir",    32'(bus.pc_redirect), 32'd1);
        chk("mp2.redir_pc", 32'(bus.redirect_pc), 32'h0044);
        next_cycle();
        sample();
        chk("mp3.redir", 32'(bus.pc_redirect), 32'd0);
        chk_cnt("mp3");
        next_cycle();

        // ---------------- reset pulse in WAIT_D with pending redirect -------
        bus.id_valid     = 1'b1;
        bus.id_is_ctrl   = 1'b1;
        bus.id_pred_pc   = 16'h0001;
        bus.id_actual_pc = 16'h0055;
        flush_now        = 1'b1;
        next_cycle();
        idle();
        bus.d_req   = 1'b1;
        stall_now   = 1'b1;
        next_cycle();
        stall_now   = 1'b1;
        sample();
        chk("rd.state", 32'(bus.state),       32'd2);
        chk("rd.redir", 32'(bus.pc_redirect), 32'd1);
        #1;
        reset_n   = 1'b0;
        exp_stall = '0;
        exp_flush = '0;
        stall_now = 1'b0;
        #1;
        chk("rd.rst.state",    32'(bus.state),       32'd0);
        chk("rd.rst.redir",    32'(bus.pc_redirect), 32'd0);
        chk("rd.rst.redir_pc", 32'(bus.redirect_pc), 32'd0);
        chk("rd.rst.en",       32'(en_vec()),        32'(EN_RUN));
        chk_cnt("rd.rst");
        next_cycle();
        sample();
        #1;
        reset_n = 1'b1;
        idle();
        next_cycle();
        sample();
        chk("rd.post.en", 32'(en_vec()), 32'(EN_RUN));

        // ---------------- 20 stall cycles: counter saturation ---------------
        next_cycle();
        bus.d_req   = 1'b1;
        bus.d_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            stall_now = 1'b1;
            next_cycle();
        end
        bus.d_ready = 1'b1;
        sample();
        chk("sat.en", 32'(en_vec()), 32'(EN_RUN));
        chk_cnt("sat");
        next_cycle();
        idle();
        next_cycle();
        sample();
        chk("sat.state", 32'(bus.state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net: the stimulus is fixed-length, this only catches a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
